// File: rtl/inst_loader.sv
// inst_loader: boot-time program loader for the instruction RAM.
// Receives a framed little-endian byte stream (count, words, XOR checksum),
// writes each assembled word to consecutive word addresses and releases the
// core only once a complete, checksum-clean image has been written.
module inst_loader #(
   parameter int             w         = 32,
   parameter logic [w-1:0]   BASE_ADDR = '0,
   parameter int             MAX_WORDS = 2048
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic         rx_ready,
   output logic         is_write,
   output logic [w-1:0] im_addr,
   output logic [w-1:0] im_inst,
   output logic         core_hold,
   output logic         done,
   output logic         error
);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [31:0]  MAX_LIMIT = 32'(MAX_WORDS);
   localparam logic [w-1:0] ADDR_STEP = w'(4);

   state_t        state;
   state_t        next_state;

   logic [1:0]    byte_cnt;
   logic [7:0]    cnt_lo;
   logic [15:0]   word_cnt;
   logic [15:0]   index;
   logic [7:0]    xor_acc;
   logic [23:0]   word_buf;
   logic [w-1:0]  wr_addr;

   logic          stage_valid;
   logic [w-1:0]  stage_addr;
   logic [w-1:0]  stage_inst;

   logic          accept;
   logic [15:0]   hdr_count;
   logic          oversize;
   logic          last_byte;
   logic          last_word;
   logic          word_complete;

   assign accept        = rx_valid && rx_ready;
   assign hdr_count     = {rx_data, cnt_lo};
   assign oversize      = {16'd0, hdr_count} > MAX_LIMIT;
   assign last_byte     = (byte_cnt == 2'd3);
   assign last_word     = (index == word_cnt - 16'd1);
   assign word_complete = accept && (state == S_DATA) && last_byte;

   // Handshake: ready only in the receiving states, never while in reset or during a start pulse.
   always_comb begin
      rx_ready = 1'b0;
      if (rst_n && !start) begin
         case (state)
            S_HDR0, S_HDR1, S_DATA, S_CSUM: rx_ready = 1'b1;
            default:                        rx_ready = 1'b0;
         endcase
      end
   end

   // Next-state logic for the frame parser; start always forces a fresh frame.
   always_comb begin
      next_state = state;
      case (state)
         S_HDR0: begin
            if (accept) next_state = S_HDR1;
         end
         S_HDR1: begin
            if (accept) begin
               if (oversize)                next_state = S_ERR;
               else if (hdr_count == 16'd0) next_state = S_CSUM;
               else                         next_state = S_DATA;
            end
         end
         S_DATA: begin
            if (accept && last_byte && last_word) next_state = S_CSUM;
         end
         S_CSUM: begin
            if (accept) begin
               if (rx_data == xor_acc) next_state = S_DONE;
               else                    next_state = S_ERR;
            end
         end
         S_DONE:  next_state = S_DONE;
         S_ERR:   next_state = S_ERR;
         default: next_state = S_HDR0;
      endcase
      if (start) next_state = S_HDR0;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_HDR0;
      else        state <= next_state;
   end

   // Frame bookkeeping: header capture, running XOR, byte assembly and word addressing.
   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         byte_cnt <= 2'd0;
         cnt_lo   <= 8'd0;
         word_cnt <= 16'd0;
         index    <= 16'd0;
         xor_acc  <= 8'd0;
         word_buf <= 24'd0;
         wr_addr  <= BASE_ADDR;
      end else if (accept) begin
         case (state)
            S_HDR0: begin
               cnt_lo  <= rx_data;
               xor_acc <= xor_acc ^ rx_data;
            end
            S_HDR1: begin
               word_cnt <= hdr_count;
               xor_acc  <= xor_acc ^ rx_data;
            end
            S_DATA: begin
               xor_acc  <= xor_acc ^ rx_data;
               byte_cnt <= byte_cnt + 2'd1;
               case (byte_cnt)
                  2'd0: word_buf[7:0]   <= rx_data;
                  2'd1: word_buf[15:8]  <= rx_data;
                  2'd2: word_buf[23:16] <= rx_data;
                  default: begin
                     index   <= index + 16'd1;
                     wr_addr <= wr_addr + ADDR_STEP;
                  end
               endcase
            end
            default: begin
               xor_acc <= xor_acc;
            end
         endcase
      end
   end

   // Stage a completed word so the strobe is driven from registers one cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         stage_valid <= 1'b0;
         stage_addr  <= BASE_ADDR;
         stage_inst  <= '0;
      end else begin
         stage_valid <= word_complete;
         if (word_complete) begin
            stage_addr <= wr_addr;
            stage_inst <= w'({rx_data, word_buf});
         end
      end
   end

   // Registered RAM write port and status; a pulse already on the bus finishes even if start arrives.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         is_write  <= 1'b0;
         im_addr   <= BASE_ADDR;
         im_inst   <= '0;
         core_hold <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         is_write <= stage_valid && !start;
         if (stage_valid && !start) begin
            im_addr <= stage_addr;
            im_inst <= stage_inst;
         end
         done      <= (next_state == S_DONE);
         error     <= (next_state == S_ERR);
         core_hold <= (next_state != S_DONE);
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: two instances (base 0x0 and base 0x100) share one
// byte stream; a frame-level model predicts writes, latency and final status.
module tb_inst_loader;

   localparam int MAXW = 2048;

   logic        clk = 1'b0;
   logic        rst_n, start, rx_valid;
   logic [7:0]  rx_data;
   logic        rdy0, wr0, hold0, done0, err0;
   logic        rdy1, wr1, hold1, done1, err1;
   logic [31:0] addr0, inst0, addr1, inst1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
      int          cyc;
   } wr_t;

   typedef struct {
      string      name;
      int         n;
      bit         fixed;
      logic [7:0] delta;
      bit         throttle;
      bit         expDone;
      bit         expErr;
   } vec_t;

   wr_t         got0[$];
   wr_t         got1[$];
   logic [7:0]  frame[$];
   logic [31:0] expWords[$];
   int          accCyc[$];

   inst_loader #(.w(32), .BASE_ADDR(32'h0), .MAX_WORDS(MAXW)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rdy0), .is_write(wr0), .im_addr(addr0), .im_inst(inst0),
      .core_hold(hold0), .done(done0), .error(err0));

   inst_loader #(.w(32), .BASE_ADDR(32'h100), .MAX_WORDS(MAXW)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rdy1), .is_write(wr1), .im_addr(addr1), .im_inst(inst1),
      .core_hold(hold1), .done(done1), .error(err1));

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter, advanced on every active edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Record every cycle in which a write strobe is seen, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr0 === 1'b1) got0.push_back('{addr: addr0, inst: inst0, cyc: cyc});
      if (wr1 === 1'b1) got1.push_back('{addr: addr1, inst: inst1, cyc: cyc});
   end

   // Global safety net against a hung handshake.
   initial begin
      #5000000;
      $display("[TB] FAIL global timeout");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Present one byte (optionally after random idle gaps) and wait for it to transfer.
   task automatic applyStimulus(input logic [7:0] b, input bit throttle);
      int waited;
      int gap;
      if (throttle) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      rx_valid = 1'b1;
      rx_data  = b;
      #1;
      waited = 0;
      while (!(rdy0 === 1'b1 && rdy1 === 1'b1) && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (waited >= 20) begin
         checks++;
         errors++;
         $display("[TB] FAIL ready timeout: rx_ready %b/%b, expected 1", rdy0, rdy1);
         rx_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      accCyc.push_back(cyc);
      rx_valid = 1'b0;
   endtask

   // One-cycle start pulse with a byte presented alongside it.
   task automatic pulseStart();
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      #1;
      checkOutput("ready in start cycle 0", 32'(rdy0), 32'd0);
      checkOutput("ready in start cycle 1", 32'(rdy1), 32'd0);
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
      checkOutput("done after start", 32'(done0), 32'd0);
      checkOutput("error after start", 32'(err0), 32'd0);
      checkOutput("hold after start", 32'(hold0), 32'd1);
   endtask

   // Build a frame of n words (fixed test words or random) with checksum xor'd by delta.
   task automatic buildFrame(input int n, input bit fixed, input logic [7:0] delta);
      logic [31:0] wd;
      logic [7:0]  x;
      frame.delete();
      frame.push_back(n[7:0]);
      frame.push_back(n[15:8]);
      if (n <= MAXW) begin
         for (int k = 0; k < n; k++) begin
            if (fixed) wd = (k == 0) ? 32'h0000_0013 : 32'h0000_006F;
            else       wd = $urandom;
            for (int j = 0; j < 4; j++) frame.push_back(wd[8*j +: 8]);
         end
         x = 8'h00;
         foreach (frame[i]) x ^= frame[i];
         frame.push_back(x ^ delta);
      end
   endtask

   // Frame-level reference: how many bytes get accepted, which words land, final status.
   task automatic modelFrame(output int nacc, output bit mdone, output bit merr);
      int         n;
      logic [7:0] x;
      expWords.delete();
      n = int'({frame[1], frame[0]});
      if (n > MAXW) begin
         nacc  = 2;
         mdone = 1'b0;
         merr  = 1'b1;
         return;
      end
      for (int k = 0; k < n; k++)
         expWords.push_back({frame[2+4*k+3], frame[2+4*k+2], frame[2+4*k+1], frame[2+4*k]});
      x = 8'h00;
      for (int i = 0; i < 2 + 4*n; i++) x ^= frame[i];
      nacc  = 3 + 4*n;
      mdone = (frame[2+4*n] == x);
      merr  = !mdone;
   endtask

   // Send the accepted part of the current frame and compare status and writes.
   task automatic runFrame(input string name, input bit throttle, input bit expDone,
                           input bit expErr, input int nacc);
      int last;
      got0.delete();
      got1.delete();
      accCyc.delete();
      for (int i = 0; i < nacc; i++) applyStimulus(frame[i], throttle);
      checkOutput($sformatf("%s done0", name), 32'(done0), 32'(expDone));
      checkOutput($sformatf("%s done1", name), 32'(done1), 32'(expDone));
      checkOutput($sformatf("%s error0", name), 32'(err0), 32'(expErr));
      checkOutput($sformatf("%s error1", name), 32'(err1), 32'(expErr));
      checkOutput($sformatf("%s hold0", name), 32'(hold0), 32'(!expDone));
      checkOutput($sformatf("%s ready0", name), 32'(rdy0), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput($sformatf("%s writes0", name), 32'(got0.size()), 32'(expWords.size()));
      checkOutput($sformatf("%s writes1", name), 32'(got1.size()), 32'(expWords.size()));
      for (int k = 0; k < expWords.size(); k++) begin
         if (k < got0.size()) begin
            checkOutput($sformatf("%s addr0[%0d]", name, k), got0[k].addr, 32'(4*k));
            checkOutput($sformatf("%s inst0[%0d]", name, k), got0[k].inst, expWords[k]);
            if (accCyc.size() > 2 + 4*k + 3)
               checkOutput($sformatf("%s latency[%0d]", name, k), 32'(got0[k].cyc),
                           32'(accCyc[2+4*k+3] + 1));
         end
         if (k < got1.size()) begin
            checkOutput($sformatf("%s addr1[%0d]", name, k), got1[k].addr, 32'h100 + 32'(4*k));
            checkOutput($sformatf("%s inst1[%0d]", name, k), got1[k].inst, expWords[k]);
         end
      end
      if (expWords.size() > 0) begin
         last = expWords.size() - 1;
         checkOutput($sformatf("%s addr0 hold", name), addr0, 32'(4*last));
         checkOutput($sformatf("%s inst0 hold", name), inst0, expWords[last]);
      end
   endtask

   initial begin
      vec_t vecs[8];
      int   nacc;
      bit   md, me;
      int   n;
      logic [7:0] delta;
      bit   thr;

      vecs[0] = '{name: "load2",      n: 2,     fixed: 1'b1, delta: 8'h00, throttle: 1'b0, expDone: 1'b1, expErr: 1'b0};
      vecs[1] = '{name: "badcsum",    n: 2,     fixed: 1'b1, delta: 8'h01, throttle: 1'b0, expDone: 1'b0, expErr: 1'b1};
      vecs[2] = '{name: "oversize",   n: 2049,  fixed: 1'b0, delta: 8'h00, throttle: 1'b0, expDone: 1'b0, expErr: 1'b1};
      vecs[3] = '{name: "zero",       n: 0,     fixed: 1'b0, delta: 8'h00, throttle: 1'b0, expDone: 1'b1, expErr: 1'b0};
      vecs[4] = '{name: "throttle3",  n: 3,     fixed: 1'b0, delta: 8'h00, throttle: 1'b1, expDone: 1'b1, expErr: 1'b0};
      vecs[5] = '{name: "max2048",    n: 2048,  fixed: 1'b0, delta: 8'h00, throttle: 1'b0, expDone: 1'b1, expErr: 1'b0};
      vecs[6] = '{name: "cnt65535",   n: 65535, fixed: 1'b0, delta: 8'h00, throttle: 1'b0, expDone: 1'b0, expErr: 1'b1};
      vecs[7] = '{name: "bad1thr",    n: 1,     fixed: 1'b0, delta: 8'h80, throttle: 1'b1, expDone: 1'b0, expErr: 1'b1};

      rst_n    = 1'b0;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset ready", 32'(rdy0), 32'd0);
      checkOutput("reset is_write", 32'(wr0), 32'd0);
      checkOutput("reset addr0", addr0, 32'h0);
      checkOutput("reset addr1", addr1, 32'h100);
      checkOutput("reset inst", inst0, 32'h0);
      checkOutput("reset hold", 32'(hold0), 32'd1);
      checkOutput("reset done", 32'(done0), 32'd0);
      checkOutput("reset error", 32'(err0), 32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("ready after reset", 32'(rdy0), 32'd1);
      @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         if (v > 0) pulseStart();
         buildFrame(vecs[v].n, vecs[v].fixed, vecs[v].delta);
         modelFrame(nacc, md, me);
         runFrame(vecs[v].name, vecs[v].throttle, vecs[v].expDone, vecs[v].expErr, nacc);
      end

      // Abort after 6 data bytes: only the completed first word is written.
      pulseStart();
      buildFrame(2, 1'b1, 8'h00);
      got0.delete();
      for (int i = 0; i < 8; i++) applyStimulus(frame[i], 1'b0);
      pulseStart();
      repeat (3) @(negedge clk);
      checkOutput("abort writes", 32'(got0.size()), 32'd1);
      if (got0.size() > 0) checkOutput("abort word", got0[0].inst, 32'h13);
      buildFrame(2, 1'b1, 8'h00);
      modelFrame(nacc, md, me);
      runFrame("reload", 1'b0, 1'b1, 1'b0, nacc);

      // Reset mid-frame while the first word's strobe is on the bus.
      pulseStart();
      buildFrame(3, 1'b0, 8'h00);
      for (int i = 0; i < 7; i++) applyStimulus(frame[i], 1'b0);
      checkOutput("strobe before reset", 32'(wr0), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("ready in reset", 32'(rdy0), 32'd0);
      @(negedge clk);
      checkOutput("mid reset is_write", 32'(wr0), 32'd0);
      checkOutput("mid reset addr0", addr0, 32'h0);
      checkOutput("mid reset addr1", addr1, 32'h100);
      checkOutput("mid reset inst", inst0, 32'h0);
      checkOutput("mid reset hold", 32'(hold0), 32'd1);
      checkOutput("mid reset done", 32'(done0), 32'd0);
      checkOutput("mid reset error", 32'(err0), 32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("ready after mid reset", 32'(rdy0), 32'd1);
      @(negedge clk);
      buildFrame(2, 1'b1, 8'h00);
      modelFrame(nacc, md, me);
      runFrame("after reset", 1'b0, 1'b1, 1'b0, nacc);

      // Randomized frames checked against the frame model.
      for (int r = 0; r < 25; r++) begin
         pulseStart();
         if ($urandom_range(0, 9) == 0) n = $urandom_range(2049, 65535);
         else                           n = $urandom_range(0, 6);
         delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         thr   = 1'($urandom_range(0, 1));
         buildFrame(n, 1'b0, delta);
         modelFrame(nacc, md, me);
         runFrame($sformatf("rand%0d", r), thr, md, me, nacc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader that drives the write port of the core's instruction RAM (`is_write`, `im_addr`, `im_inst`). It accepts a framed little-endian byte stream over a valid/ready handshake, typically from a UART receiver. It assembles 32-bit instruction words, writes each one to consecutive word addresses, and verifies an XOR checksum. The core is held off (`core_hold`) until a complete, checksum-clean image has been written.

## Interface
Parameters:
- `w`, 32: instruction / address width (matches instruction RAM).
- `BASE_ADDR`, 0: byte address of the first written word.
- `MAX_WORDS`, 2048: largest accepted word count; capacity of the target RAM.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle pulse; aborts any load and restarts framing.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader can accept a byte; transfer happens when `rx_valid && rx_ready`.
- `is_write`  out  1  one-cycle write strobe to instruction RAM.
- `im_addr`  out  w  byte address for the write (word-aligned).
- `im_inst`  out  w  instruction word to write.
- `core_hold`  out  1  keep the core stalled/reset while high.
- `done`  out  1  image loaded and checksum matched; sticky.
- `error`  out  1  framing or checksum failure; sticky.

## Operation
- Frame format:
  - CNT_LO, CNT_HI: word count N, 16-bit little-endian.
  - N×4 data bytes: each word little-endian, so the first byte lands in bits [7:0].
  - CSUM: XOR of every preceding frame byte, header included.
- States and transitions:
  - HDR0: take CNT_LO, go to HDR1.
  - HDR1: take CNT_HI.
    - N > MAX_WORDS: go to ERR.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA: collect bytes with a 2-bit byte counter. On the 4th byte, stage the word. After the Nth word, go to CSUM.
  - CSUM: compare the received byte with the running XOR.
    - Match: go to DONE.
    - Mismatch: go to ERR.
  - DONE and ERR are terminal until `start` or reset.
- `rx_ready` is 1 in HDR0, HDR1, DATA and CSUM, and 0 in DONE and ERR. It is also forced to 0 in any cycle where `start` is 1.
- Write addressing: word k (0-based) is written at `im_addr = BASE_ADDR + 4*k`. Address arithmetic is w bits wide and wraps modulo 2^w.
- The running XOR and the word index clear on reset and on `start`.
- `start` in any state:
  - next state is HDR0;
  - `done`, `error`, byte counter, index and XOR are cleared;
  - `core_hold` is set to 1.
  - A byte presented in the same cycle is not accepted.
- Reset values:
  - state HDR0;
  - `rx_ready` 0 while `rst_n` is 0, and 1 from the first cycle after reset releases;
  - `is_write` 0;
  - `im_addr` BASE_ADDR;
  - `im_inst` 0;
  - `core_hold` 1;
  - `done` 0;
  - `error` 0.
- Reset asserted mid-load discards the partial word. Words already written stay in the RAM, but `done` stays 0.

## Timing
- Every byte can be accepted back-to-back, one per cycle. The handshake never stalls for a RAM write.
- Write latency:
  - The 4th byte of word k is accepted at edge T.
  - At edge T+1, `is_write` goes to 1 for exactly one cycle, with `im_addr` and `im_inst` stable for that whole cycle.
  - The RAM captures the word at edge T+2.
- `im_addr` and `im_inst` hold their values after the strobe until the next write.
- Checksum byte accepted at edge T:
  - match: `done` = 1 and `core_hold` = 0 from T+1;
  - mismatch: `error` = 1 from T+1 and `core_hold` stays 1.
- The last data word's `is_write` pulse can coincide with the checksum acceptance cycle. Both are required to complete normally.
- If `start` arrives in the cycle a staged write is pulsing, the pulse still completes; no further writes follow.

## Test plan
- Load 2 words:
  - Stimulus: bytes 02 00 13 00 00 00 6F 00 00 00, then CSUM = 02^13^6F = 0x7E.
  - Response: `is_write` pulses at 0x0 with 0x00000013 and at 0x4 with 0x0000006F; `done` = 1 and `core_hold` = 0 one cycle after the CSUM byte.
- Bad checksum:
  - Stimulus: the same frame with CSUM 0x7F.
  - Response: both writes still occur; `error` = 1, `done` = 0, `core_hold` = 1, `rx_ready` = 0.
- Oversize count:
  - Stimulus: header 01 08 (N = 2049) with MAX_WORDS = 2048.
  - Response: ERR one cycle after CNT_HI; no `is_write`.
- Zero-length image:
  - Stimulus: 00 00 00.
  - Response: `done` = 1; no writes.
- Throttled stream:
  - Stimulus: random `rx_valid` gaps; BASE_ADDR = 0x100; 3 words.
  - Response: addresses 0x100, 0x104, 0x108 in order; exactly 3 strobes.
- Abort and reload:
  - Stimulus: `start` pulsed after 6 data bytes, then the 2-word frame from the first test.
  - Response: the `start` cycle has `rx_ready` = 0 and no partial word is written; the reload writes 0x0 and 0x4 and ends with `done` = 1.
  - Also: `rst_n` = 0 mid-frame returns all outputs to their reset values in one cycle.
